// File: rtl/jogo_pkg.sv
// jogo_pkg: shared types, constants and helper functions for the game datapath and control unit.
// Revision 1.0
`default_nettype none

package jogo_pkg;

  localparam int N_CELULAS = 9;
  localparam int JOGADA_W  = 4;

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    FILTRA       = 2'd1,
    SINALIZA     = 2'd2,
    ESPERA_SOLTA = 2'd3
  } det_estado_t;

  typedef enum logic [3:0] {
    UC_INICIAL     = 4'd0,
    UC_PREPARA     = 4'd1,
    UC_JOGAR_MACRO = 4'd2,
    UC_REG_MACRO   = 4'd3,
    UC_JOGAR_MICRO = 4'd4,
    UC_REG_MICRO   = 4'd5,
    UC_VERIFICA    = 4'd6,
    UC_TROCA       = 4'd7,
    UC_FIM         = 4'd8
  } uc_estado_t;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  function automatic logic eh_one_hot(input logic [N_CELULAS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [JOGADA_W-1:0] codifica(input logic [N_CELULAS-1:0] v);
    logic [JOGADA_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CELULAS; i++) begin
      if (v[i]) idx = JOGADA_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sincronizador.sv
// sincronizador: two-flop synchronizer of configurable width, async reset to zero.
// Revision 1.0
`default_nettype none

module sincronizador #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/detector_jogada.sv
// detector_jogada: synchronizes, debounces and validates a single cell button press,
// emitting a one-cycle strobe with the 4-bit cell code. Revision 1.0
`default_nettype none

module detector_jogada
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_zera,
  input  logic                 i_habilita,
  input  logic [N_CELULAS-1:0] i_botoes,
  output logic                 o_tem_jogada,
  output logic [JOGADA_W-1:0]  o_jogada,
  output logic [1:0]           o_db_estado
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CELULAS-1:0] w_bs;
  det_estado_t          r_estado, w_prox;
  logic [N_CELULAS-1:0] r_cap, w_cap_prox;
  logic [CNT_W-1:0]     r_cnt, w_cnt_prox;
  logic [JOGADA_W-1:0]  r_jogada, w_jogada_prox;
  logic                 r_tem_jogada;

  sincronizador #(
    .WIDTH (N_CELULAS)
  ) u_sincronizador (
    .clock (clock),
    .reset (reset),
    .i_d   (i_botoes),
    .o_q   (w_bs)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado     <= OCIOSO;
      r_cap        <= '0;
      r_cnt        <= '0;
      r_jogada     <= '0;
      r_tem_jogada <= 1'b0;
    end else begin
      r_estado     <= w_prox;
      r_cap        <= w_cap_prox;
      r_cnt        <= w_cnt_prox;
      r_jogada     <= w_jogada_prox;
      r_tem_jogada <= (w_prox == SINALIZA);
    end
  end

  always_comb begin
    w_prox        = r_estado;
    w_cap_prox    = r_cap;
    w_cnt_prox    = r_cnt;
    w_jogada_prox = r_jogada;

    if (i_zera) begin
      w_prox        = OCIOSO;
      w_cap_prox    = '0;
      w_cnt_prox    = '0;
      w_jogada_prox = '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (i_habilita && eh_one_hot(w_bs)) begin
            w_cap_prox = w_bs;
            w_cnt_prox = '0;
            w_prox     = FILTRA;
          end
        end
        FILTRA: begin
          if ((w_bs != r_cap) || !i_habilita) begin
            w_prox = OCIOSO;
          end else if (r_cnt == CNT_MAX) begin
            w_prox        = SINALIZA;
            w_jogada_prox = codifica(r_cap);
          end else begin
            w_cnt_prox = r_cnt + 1'b1;
          end
        end
        SINALIZA: begin
          w_cnt_prox = '0;
          w_prox     = ESPERA_SOLTA;
        end
        ESPERA_SOLTA: begin
          // Any held button restarts the release window, so one press yields one strobe.
          if (w_bs != '0) begin
            w_cnt_prox = '0;
          end else if (r_cnt == CNT_MAX) begin
            w_prox = OCIOSO;
          end else begin
            w_cnt_prox = r_cnt + 1'b1;
          end
        end
        default: w_prox = OCIOSO;
      endcase
    end
  end

  assign o_tem_jogada = r_tem_jogada;
  assign o_jogada     = r_jogada;
  assign o_db_estado  = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: directed and random stimulus compared cycle by cycle against a behavioural model.
// Revision 1.0
`default_nettype none

module tb_detector_jogada;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       zera  = 1'b0;
  logic       hab   = 1'b0;
  logic [8:0] botoes = '0;
  logic       tem;
  logic [3:0] jog;
  logic [1:0] est;

  always #5 clock = ~clock;

  detector_jogada #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .i_zera       (zera),
    .i_habilita   (hab),
    .i_botoes     (botoes),
    .o_tem_jogada (tem),
    .o_jogada     (jog),
    .o_db_estado  (est)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 filtering, 2 flagging, 3 waiting for release.
  logic [8:0] pipe[$];
  int         m_phase;
  int         m_run;
  int         m_quiet;
  logic [8:0] m_cand;
  logic [3:0] m_jog;
  int         strobes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(9'd0);
    pipe.push_back(9'd0);
    m_phase = 0;
    m_run   = 0;
    m_quiet = 0;
    m_cand  = '0;
    m_jog   = '0;
  endtask

  function automatic int index_of(input logic [8:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 9; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic cycle();
    logic [8:0] bs;
    @(posedge clock);
    bs = pipe.pop_front();
    pipe.push_back(botoes);
    if (reset) begin
      model_reset();
    end else if (zera) begin
      m_phase = 0;
      m_run   = 0;
      m_cand  = '0;
      m_jog   = '0;
    end else begin
      case (m_phase)
        0: if (hab && $countones(bs) == 1) begin
             m_cand  = bs;
             m_run   = 0;
             m_phase = 1;
           end
        1: if (bs !== m_cand || !hab) m_phase = 0;
           else if (m_run == D - 1) begin
             m_phase = 2;
             m_jog   = 4'(index_of(m_cand));
           end else m_run++;
        2: begin
             m_phase = 3;
             m_quiet = 0;
           end
        default: if (bs != 0) m_quiet = 0;
                 else if (m_quiet == D - 1) m_phase = 0;
                 else m_quiet++;
      endcase
    end
    #1;
    if (m_phase == 2) strobes++;
    check("tem_jogada", 32'(tem), 32'(m_phase == 2));
    check("jogada", 32'(jog), 32'(m_jog));
    check("db_estado", 32'(est), 32'(m_phase));
  endtask

  task automatic run(input int n, input logic [8:0] b);
    botoes = b;
    repeat (n) cycle();
  endtask

  int s0;
  int first_idx;

  initial begin
    model_reset();
    repeat (2) cycle();
    check("reset_tem", 32'(tem), 32'd0);
    check("reset_jogada", 32'(jog), 32'd0);
    check("reset_estado", 32'(est), 32'd0);
    reset = 1'b0;
    hab   = 1'b1;

    // Clean press on cell 4: strobe on the 7th edge after driving the raw input.
    s0 = strobes;
    first_idx = -1;
    botoes = 9'b000010000;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (tem === 1'b1 && first_idx < 0) first_idx = i;
    end
    check("clean_latency", 32'(first_idx), 32'd7);
    check("clean_count", 32'(strobes - s0), 32'd1);
    check("clean_code", 32'(jog), 32'd4);
    run(8, 9'd0);

    // Bounce on cell 2, then stable hold.
    s0 = strobes;
    for (int i = 0; i < 5; i++) run(2, (i % 2 == 0) ? 9'd4 : 9'd0);
    check("bounce_quiet", 32'(strobes - s0), 32'd0);
    run(15, 9'd4);
    check("bounce_count", 32'(strobes - s0), 32'd1);
    check("bounce_code", 32'(jog), 32'd2);
    run(8, 9'd0);

    // Two buttons then a single one.
    s0 = strobes;
    run(10, 9'b100000001);
    check("multi_none", 32'(strobes - s0), 32'd0);
    run(15, 9'b100000000);
    check("multi_count", 32'(strobes - s0), 32'd1);
    check("multi_code", 32'(jog), 32'd8);
    run(8, 9'd0);

    // Disabled, then enable dropped during filtering.
    s0 = strobes;
    hab = 1'b0;
    run(10, 9'd2);
    run(2, 9'd0);
    hab = 1'b1;
    run(5, 9'd2);
    hab = 1'b0;
    run(2, 9'd2);
    check("disable_state", 32'(est), 32'd0);
    run(4, 9'd0);
    check("disable_count", 32'(strobes - s0), 32'd0);
    hab = 1'b1;

    // Release guard on cell 3.
    s0 = strobes;
    run(12, 9'd8);
    run(2, 9'd0);
    run(10, 9'd8);
    check("guard_count", 32'(strobes - s0), 32'd1);
    run(8, 9'd0);
    run(10, 9'd8);
    check("guard_repress", 32'(strobes - s0), 32'd2);
    run(8, 9'd0);

    // zera during filtering.
    s0 = strobes;
    run(5, 9'd32);
    zera = 1'b1;
    run(1, 9'd0);
    zera = 1'b0;
    check("zera_state", 32'(est), 32'd0);
    check("zera_code", 32'(jog), 32'd0);
    run(10, 9'd0);
    check("zera_count", 32'(strobes - s0), 32'd0);

    // Asynchronous reset while the strobe is showing.
    run(7, 9'd64);
    check("pre_reset_tem", 32'(tem), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("async_tem", 32'(tem), 32'd0);
    check("async_jogada", 32'(jog), 32'd0);
    check("async_estado", 32'(est), 32'd0);
    model_reset();
    botoes = 9'd0;
    run(2, 9'd0);
    reset = 1'b0;

    // Asynchronous reset mid-filtering: no strobe afterwards.
    s0 = strobes;
    run(5, 9'd128);
    #3 reset = 1'b1;
    #1;
    check("async_f_estado", 32'(est), 32'd0);
    model_reset();
    run(2, 9'd0);
    reset = 1'b0;
    run(10, 9'd0);
    check("async_f_count", 32'(strobes - s0), 32'd0);

    // Random bursts.
    for (int b = 0; b < 40; b++) begin
      int kind;
      logic [8:0] v;
      hab  = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 3);
      if (kind == 0) v = 9'd0;
      else if (kind == 3) v = 9'($urandom_range(1, 511));
      else v = 9'd1 << $urandom_range(0, 8);
      zera = ($urandom_range(0, 19) == 0);
      run(1, v);
      zera = 1'b0;
      run($urandom_range(0, 10), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/detector_jogada.md
# detector_jogada

Captures a player's move from the nine raw cell/board push-buttons. Synchronizes, debounces and validates the press (exactly one button), then presents a 4-bit cell code with a one-cycle `tem_jogada` strobe. It sits directly upstream of the game control unit, which consumes `tem_jogada` in its macro-play and micro-play states. The same block serves both macro-board and micro-cell selection; the control unit decides which register captures `jogada`.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: stable cycles required for both press and release (1 ms at 50 MHz); legal range ≥ 2.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `zera`  in  1  synchronous clear, driven by the control unit's `zeraEdge`.
- `habilita`  in  1  accept new presses; driven by `jogar_macro | jogar_micro`.
- `botoes`  in  9  raw asynchronous buttons, active-high; bit i is cell i.
- `tem_jogada`  out  1  one-cycle strobe: a valid move was confirmed.
- `jogada`  out  4  code of the last confirmed move, 0..8.
- `db_estado`  out  2  current FSM state, for debug.

## Operation
- `botoes` passes through a 2-flop synchronizer. All logic below uses the synchronized vector `bs`.
- A 9-bit capture register `cap` holds the press candidate. The counter `cnt` has width clog2(DEBOUNCE_CYCLES).
- FSM states: OCIOSO=0, FILTRA=1, SINALIZA=2, ESPERA_SOLTA=3.
- **OCIOSO**
  - If `habilita` is 1 and `bs` is one-hot: set `cap`←`bs`, `cnt`←0, go to FILTRA.
  - Zero buttons pressed, or two or more pressed: stay in OCIOSO.
- **FILTRA**
  - If `bs` differs from `cap`, or `habilita` is 0: go to OCIOSO. No strobe is issued.
  - Else if `cnt` = DEBOUNCE_CYCLES−1: go to SINALIZA and load `jogada` with the index of the set bit of `cap`.
  - Else: `cnt`++.
- **SINALIZA**
  - `tem_jogada`=1 for this cycle only.
  - Set `cnt`←0 and go to ESPERA_SOLTA unconditionally.
- **ESPERA_SOLTA**
  - Any bit of `bs` set: `cnt`←0.
  - Else `cnt`++. When `cnt` = DEBOUNCE_CYCLES−1 with all buttons released, go to OCIOSO.
  - `habilita` is ignored in this state. A held button can never produce a second strobe.
- **`zera`** has priority over every transition. It forces OCIOSO and sets `cnt`←0, `cap`←0, `jogada`←0. The synchronizer is not cleared.
- `jogada` holds its value until the next SINALIZA, `zera`, or `reset`.
- `db_estado` = state encoding.

## Timing
- **Reset values:** state OCIOSO; `tem_jogada`=0; `jogada`=0; `db_estado`=0; `cnt`=0; `cap`=0; synchronizer flops 0.
- **Latency:**
  - A raw press is visible in `bs` 2 cycles after being sampled.
  - Define cycle 0 as the cycle OCIOSO sees the one-hot `bs`. FILTRA then occupies cycles 1..D.
  - `tem_jogada`=1 in cycle D+1, with `jogada` already valid in that same cycle.
- **Glitch:** a bounce that changes `bs` during FILTRA restarts detection from OCIOSO. The full D stable cycles are required again.
- **Simultaneous events:**
  - `zera` in the SINALIZA cycle: the registered strobe still shows that cycle, the state clears next cycle, and `jogada`←0.
  - `zera` and a press in the same cycle: `zera` wins and no capture happens.
- **Mid-operation reset:** `reset` at any point immediately returns all outputs to their reset values. No strobe is issued afterward for a press that was in progress.
- **Outputs:** `tem_jogada` and `jogada` are registered (Moore), with no combinational path from `botoes`.

## Structure
- Shared package `jogo_pkg`:
  - state encodings OCIOSO/FILTRA/SINALIZA/ESPERA_SOLTA;
  - `JOGADA_W`=4;
  - `N_CELULAS`=9.
  - The control-unit state constants also belong in this package.
- One sub-module, `sincronizador`: parameterized width, 2-flop, async reset to 0. It is reused for the `iniciar` button.
- One-hot check and encoder: a combinational function in the package (`eh_one_hot`, `codifica`).

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Clean press:** `habilita`=1, `botoes`=9'b000010000 held 20 cycles → one `tem_jogada` pulse exactly 5 cycles after `bs` shows the press, `jogada`=4; no second pulse while held.
- **Bounce:** `botoes` toggles bit 2 every 2 cycles for 10 cycles, then holds → no strobe during bouncing; single strobe with `jogada`=2 after 4 stable cycles.
- **Multi-press:** `botoes`=9'b100000001 held → no strobe. Releasing bit 0 leaves bit 8 one-hot → strobe with `jogada`=8.
- **Disabled:** `habilita`=0 with a press → no strobe. Dropping `habilita` during FILTRA → return to OCIOSO (`db_estado`=0), no strobe.
- **Release guard:** after a strobe for cell 3, release for 2 cycles, re-press cell 3 → no strobe until 4 consecutive released cycles precede the new press.
- **`zera`/`reset` mid-FILTRA:** assert `zera` during FILTRA → `db_estado`=0, `jogada`=0, no strobe. Repeat with async `reset` between clock edges → all outputs 0 immediately.
